alu_core: RTL and testbench

//   Registered 4-bit ALU executing one operation per clock on operands A and B

---
 rtl/alu_core.sv | 85 ++++++++
 tb/tb_alu_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// rtl/alu_core.sv - registered WIDTH-bit ALU: one op per clock, result/carry/zero one cycle after in_valid
module alu_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             out_valid
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_PASS = 4'b1111;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] next_result;
    logic             next_carry;

    // Extended-width add/sub: the extra top bit is the carry out or the borrow.
    assign sum_ext  = {1'b0, A} + {1'b0, B};
    assign diff_ext = {1'b0, A} - {1'b0, B};

    always_comb begin
        next_result = '0;
        next_carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                next_result = sum_ext[WIDTH-1:0];
                next_carry  = sum_ext[WIDTH];
            end
            OP_SUB: begin
                next_result = diff_ext[WIDTH-1:0];
                next_carry  = diff_ext[WIDTH];
            end
            OP_AND:  next_result = A & B;
            OP_OR:   next_result = A | B;
            OP_NOT:  next_result = ~A;
            OP_XOR:  next_result = A ^ B;
            OP_SHL: begin
                next_result = {A[WIDTH-2:0], 1'b0};
                next_carry  = A[WIDTH-1];
            end
            OP_SHR: begin
                next_result = {1'b0, A[WIDTH-1:1]};
                next_carry  = A[0];
            end
            OP_PASS: next_result = A;
            default: begin
                next_result = '0;
                next_carry  = 1'b0;
            end
        endcase
    end

    // zero_flag is registered alongside result so it always describes the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result     <= next_result;
                carry_flag <= next_carry;
                zero_flag  <= (next_result == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - self-checking bench for alu_core against an arithmetic reference model
module tb_alu_core;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   opcode;
    logic [W-1:0] result;
    logic         carry_flag;
    logic         zero_flag;
    logic         out_valid;

    int n_cmp;
    int n_err;
    int e_res;
    int e_c;
    int e_z;

    alu_core #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .A          (A),
        .B          (B),
        .opcode     (opcode),
        .result     (result),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned operands.
    task automatic model(input int a, input int b, input int op, output int r, output int c);
        r = 0;
        c = 0;
        case (op)
            0: begin r = (a + b) % M; c = (a + b >= M) ? 1 : 0; end
            1: begin r = (a - b + M) % M; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = (M - 1) - a;
            5: r = a ^ b;
            6: begin r = (a * 2) % M; c = (a >= M / 2) ? 1 : 0; end
            7: begin r = a / 2; c = a % 2; end
            15: r = a;
            default: begin r = 0; c = 0; end
        endcase
    endtask

    task automatic check_outputs(input string tag, input int exp_valid);
        check({tag, "_result"}, 8'(result), 8'(e_res));
        check({tag, "_carry"}, 8'(carry_flag), 8'(e_c));
        check({tag, "_zero"}, 8'(zero_flag), 8'(e_z));
        check({tag, "_valid"}, 8'(out_valid), 8'(exp_valid));
    endtask

    task automatic do_op(input string tag, input int a, input int b, input int op);
        int r;
        int c;
        @(negedge clk);
        in_valid = 1'b1;
        A        = W'(a);
        B        = W'(b);
        opcode   = 4'(op);
        @(posedge clk);
        #1;
        model(a, b, op, r, c);
        e_res = r;
        e_c   = c;
        e_z   = (r == 0) ? 1 : 0;
        check_outputs(tag, 1);
    endtask

    task automatic do_hold(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        A        = W'($urandom_range(M - 1));
        B        = W'($urandom_range(M - 1));
        opcode   = 4'($urandom_range(15));
        @(posedge clk);
        #1;
        check_outputs(tag, 0);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        opcode   = '0;
        e_res    = 0;
        e_c      = 0;
        e_z      = 0;

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add_3_2", 3, 2, 0);
        check("add_3_2_lit", 8'(result), 8'd5);
        do_op("sub_5_5", 5, 5, 1);
        check("sub_5_5_zero_lit", 8'(zero_flag), 8'd1);
        do_op("sub_2_5", 2, 5, 1);
        check("sub_2_5_lit", 8'(result), 8'd13);
        check("sub_2_5_borrow_lit", 8'(carry_flag), 8'd1);
        do_op("and", 10, 12, 2);
        check("and_lit", 8'(result), 8'd8);
        do_op("or", 10, 12, 3);
        check("or_lit", 8'(result), 8'd14);
        do_op("not", 12, 5, 4);
        check("not_lit", 8'(result), 8'd3);
        do_op("xor", 10, 12, 5);
        do_op("shl_msb", 9, 0, 6);
        check("shl_carry_lit", 8'(carry_flag), 8'd1);
        do_op("shr_lsb", 9, 0, 7);
        check("shr_lit", 8'(result), 8'd4);
        do_op("pass", 9, 6, 15);
        check("pass_lit", 8'(result), 8'd9);
        do_op("add_15_1", 15, 1, 0);
        check("add_15_1_carry_lit", 8'(carry_flag), 8'd1);
        check("add_15_1_zero_lit", 8'(zero_flag), 8'd1);
        do_op("invalid_8", 3, 3, 8);
        check("invalid_zero_lit", 8'(zero_flag), 8'd1);
        do_op("invalid_14", 15, 15, 14);
        do_op("pass_seed", 6, 0, 15);
        do_hold("hold1");
        do_hold("hold2");

        // Asynchronous reset between edges clears outputs without a clock.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        e_res = 0;
        e_c   = 0;
        e_z   = 0;
        check_outputs("async_reset", 0);

        // Reset held across an edge with in_valid high discards that operation.
        @(negedge clk);
        in_valid = 1'b1;
        A        = 4'd7;
        B        = 4'd1;
        opcode   = 4'd0;
        @(posedge clk);
        #1;
        check_outputs("reset_discard", 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        do_op("after_reset", 7, 1, 0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) begin
                do_hold("rand_hold");
            end else begin
                do_op("rand_op", int'($urandom_range(M - 1)), int'($urandom_range(M - 1)),
                      int'($urandom_range(15)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
